// File: rtl/axil_cmd_pkg.sv
// Shared op codes, status codes and FSM state
// encodings for the AXI-Lite command master.
package axil_cmd_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_RMW   = 2'b10;
  localparam logic [1:0] OP_POLL  = 2'b11;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_AXI_ERR  = 2'b01;
  localparam logic [1:0] ST_POLL_LIM = 2'b10;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_WR     = 3'd2;
  localparam logic [2:0] S_WAIT_B = 3'd3;
  localparam logic [2:0] S_RSP    = 3'd4;

  localparam logic [2:0] PROT_AW = 3'b000;
  localparam logic [2:0] PROT_AR = 3'b001;

  // SLVERR and DECERR both have bit 1 set
  function automatic logic is_err(
    input logic [1:0] r
  );
    return r[1];
  endfunction

endpackage

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle; master drives AW/W/AR and
// the B/R ready strobes, slave drives the rest.
interface axil_cmd_master_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]                  M_AXI_AWPROT;
  logic                        M_AXI_AWVALID;
  logic                        M_AXI_AWREADY;
  logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                        M_AXI_WVALID;
  logic                        M_AXI_WREADY;
  logic [1:0]                  M_AXI_BRESP;
  logic                        M_AXI_BVALID;
  logic                        M_AXI_BREADY;
  logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic [2:0]                  M_AXI_ARPROT;
  logic                        M_AXI_ARVALID;
  logic                        M_AXI_ARREADY;
  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]                  M_AXI_RRESP;
  logic                        M_AXI_RVALID;
  logic                        M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT,
    output M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB,
    output M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT,
    output M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP,
    input  M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT,
    input  M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB,
    input  M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT,
    input  M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP,
    output M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axil_xfer.sv
// One single-beat AXI-Lite read or write per start
// pulse; done/resp/rdata are valid on the B/R beat.
module axil_xfer
  import axil_cmd_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      wr,
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  input  logic [AXI_DATA_WIDTH-1:0] wdata,
  output logic                      addr_done,
  output logic                      done,
  output logic [1:0]                resp,
  output logic [AXI_DATA_WIDTH-1:0] rdata,
  axil_cmd_master_if.master         m
);

  logic awv, wv, bre, arv, rre;
  logic aw_ok, w_ok, wr_q;
  logic hs_aw, hs_w, hs_b, hs_ar, hs_r;

  assign hs_aw = awv & m.M_AXI_AWREADY;
  assign hs_w  = wv  & m.M_AXI_WREADY;
  assign hs_b  = bre & m.M_AXI_BVALID;
  assign hs_ar = arv & m.M_AXI_ARREADY;
  assign hs_r  = rre & m.M_AXI_RVALID;

  assign m.M_AXI_AWADDR  = addr;
  assign m.M_AXI_AWPROT  = PROT_AW;
  assign m.M_AXI_AWVALID = awv;
  assign m.M_AXI_WDATA   = wdata;
  assign m.M_AXI_WSTRB   =
    {(AXI_DATA_WIDTH/8){1'b1}};
  assign m.M_AXI_WVALID  = wv;
  assign m.M_AXI_BREADY  = bre;
  assign m.M_AXI_ARADDR  = addr;
  assign m.M_AXI_ARPROT  = PROT_AR;
  assign m.M_AXI_ARVALID = arv;
  assign m.M_AXI_RREADY  = rre;

  // bre gates out stale aw_ok/w_ok before a write
  assign addr_done = bre
    & (aw_ok | hs_aw) & (w_ok | hs_w);
  assign done  = hs_b | hs_r;
  assign resp  = wr_q ? m.M_AXI_BRESP
                      : m.M_AXI_RRESP;
  assign rdata = m.M_AXI_RDATA;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awv   <= 1'b0;
      wv    <= 1'b0;
      bre   <= 1'b0;
      arv   <= 1'b0;
      rre   <= 1'b0;
      aw_ok <= 1'b0;
      w_ok  <= 1'b0;
      wr_q  <= 1'b0;
    end else if (start) begin
      wr_q <= wr;
      if (wr) begin
        awv   <= 1'b1;
        wv    <= 1'b1;
        bre   <= 1'b1;
        aw_ok <= 1'b0;
        w_ok  <= 1'b0;
      end else begin
        arv <= 1'b1;
        rre <= 1'b1;
      end
    end else begin
      if (hs_aw) begin
        awv   <= 1'b0;
        aw_ok <= 1'b1;
      end
      if (hs_w) begin
        wv   <= 1'b0;
        w_ok <= 1'b1;
      end
      if (hs_b)  bre <= 1'b0;
      if (hs_ar) arv <= 1'b0;
      if (hs_r)  rre <= 1'b0;
    end
  end

endmodule

// File: rtl/axil_cmd_master.sv
// Command-driven AXI-Lite master: WRITE/READ/RMW/POLL
// with error retry; one cmd in, one response out.
module axil_cmd_master
  import axil_cmd_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MAX_RETRIES    = 15,
  parameter int POLL_LIMIT     = 1024
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESETN,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic [1:0]                CMD_OP,
  input  logic [AXI_ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [AXI_DATA_WIDTH-1:0] CMD_DATA,
  input  logic [AXI_DATA_WIDTH-1:0] CMD_MASK,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic [AXI_DATA_WIDTH-1:0] RSP_DATA,
  output logic [1:0]                RSP_STATUS,
  axil_cmd_master_if.master         m_axi
);

  localparam int DW = AXI_DATA_WIDTH;

  logic [2:0]                state;
  logic [1:0]                op_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [DW-1:0]             data_q, mask_q;
  logic [DW-1:0]             rsp_q;
  logic [1:0]                st_q;
  logic [7:0]                retry_q;
  logic [16:0]               poll_q;
  logic                      kick, rdy;

  logic          x_adone, x_done;
  logic [1:0]    x_resp;
  logic [DW-1:0] x_rdata;

  axil_xfer #(
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)
  ) u_xfer (
    .clk       (M_AXI_ACLK),
    .rst_n     (M_AXI_ARESETN),
    .start     (kick),
    .wr        (state == S_WR),
    .addr      (addr_q),
    .wdata     (data_q),
    .addr_done (x_adone),
    .done      (x_done),
    .resp      (x_resp),
    .rdata     (x_rdata),
    .m         (m_axi)
  );

  logic [DW-1:0] merged;
  logic          hit, r_max, p_end;
  logic [16:0]   poll_n;

  assign merged = (x_rdata & ~mask_q)
                | (data_q & mask_q);
  assign hit    = (x_rdata & mask_q)
               == (data_q & mask_q);
  assign r_max  = retry_q == 8'(MAX_RETRIES);
  assign poll_n = poll_q + 17'd1;
  assign p_end  = poll_n == 17'(POLL_LIMIT);

  // rdy is registered so it stays low in reset
  assign CMD_READY  = rdy;
  assign RSP_VALID  = state == S_RSP;
  assign RSP_DATA   = rsp_q;
  assign RSP_STATUS = st_q;

  always_ff @(posedge M_AXI_ACLK
              or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state   <= S_IDLE;
      op_q    <= OP_WRITE;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      rsp_q   <= '0;
      st_q    <= ST_OK;
      retry_q <= '0;
      poll_q  <= '0;
      kick    <= 1'b0;
      rdy     <= 1'b0;
    end else begin
      kick <= 1'b0;
      case (state)
        S_IDLE: begin
          rdy <= 1'b1;
          if (CMD_VALID && rdy) begin
            rdy     <= 1'b0;
            op_q    <= CMD_OP;
            addr_q  <= CMD_ADDR;
            data_q  <= CMD_DATA;
            mask_q  <= CMD_MASK;
            retry_q <= '0;
            poll_q  <= '0;
            kick    <= 1'b1;
            state   <= (CMD_OP == OP_WRITE)
                       ? S_WR : S_RD;
          end
        end
        S_RD: begin
          if (x_done && is_err(x_resp)) begin
            if (r_max) begin
              st_q  <= ST_AXI_ERR;
              rsp_q <= x_rdata;
              state <= S_RSP;
            end else begin
              retry_q <= retry_q + 8'd1;
              kick    <= 1'b1;
            end
          end else if (x_done) begin
            retry_q <= '0;
            if (op_q == OP_RMW) begin
              data_q <= merged;
              kick   <= 1'b1;
              state  <= S_WR;
            end else if (op_q == OP_POLL
                         && !hit) begin
              poll_q <= poll_n;
              rsp_q  <= x_rdata;
              if (p_end) begin
                st_q  <= ST_POLL_LIM;
                state <= S_RSP;
              end else begin
                kick <= 1'b1;
              end
            end else begin
              st_q  <= ST_OK;
              rsp_q <= x_rdata;
              state <= S_RSP;
            end
          end
        end
        S_WR: begin
          if (x_adone) state <= S_WAIT_B;
        end
        S_WAIT_B: begin
          if (x_done) begin
            rsp_q <= data_q;
            if (!is_err(x_resp)) begin
              st_q  <= ST_OK;
              state <= S_RSP;
            end else if (r_max) begin
              st_q  <= ST_AXI_ERR;
              state <= S_RSP;
            end else begin
              retry_q <= retry_q + 8'd1;
              kick    <= 1'b1;
              state   <= S_WR;
            end
          end
        end
        S_RSP: begin
          if (RSP_READY) begin
            rdy   <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: default DUT plus a
// small-limit DUT sharing one reactive slave model.
module tb_axil_cmd_master;
  import axil_cmd_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  st;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [31:0] cmd_mask = '0;
  logic        rsp_ready = 1'b1;

  logic        a_cr, b_cr, a_rv, b_rv;
  logic [31:0] a_rd, b_rd;
  logic [1:0]  a_rs, b_rs;

  axil_cmd_master_if #(
    .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)
  ) ifa ();
  axil_cmd_master_if #(
    .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)
  ) ifb ();

  axil_cmd_master u_a (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .CMD_VALID     (cmd_valid & ~sel),
    .CMD_READY     (a_cr),
    .CMD_OP        (cmd_op),
    .CMD_ADDR      (cmd_addr),
    .CMD_DATA      (cmd_data),
    .CMD_MASK      (cmd_mask),
    .RSP_VALID     (a_rv),
    .RSP_READY     (rsp_ready & ~sel),
    .RSP_DATA      (a_rd),
    .RSP_STATUS    (a_rs),
    .m_axi         (ifa.master)
  );

  axil_cmd_master #(
    .MAX_RETRIES(2), .POLL_LIMIT(4)
  ) u_b (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .CMD_VALID     (cmd_valid & sel),
    .CMD_READY     (b_cr),
    .CMD_OP        (cmd_op),
    .CMD_ADDR      (cmd_addr),
    .CMD_DATA      (cmd_data),
    .CMD_MASK      (cmd_mask),
    .RSP_VALID     (b_rv),
    .RSP_READY     (rsp_ready & sel),
    .RSP_DATA      (b_rd),
    .RSP_STATUS    (b_rs),
    .m_axi         (ifb.master)
  );

  wire        cmd_ready  = sel ? b_cr : a_cr;
  wire        rsp_valid  = sel ? b_rv : a_rv;
  wire [31:0] rsp_data   = sel ? b_rd : a_rd;
  wire [1:0]  rsp_status = sel ? b_rs : a_rs;

  wire awvalid = sel ? ifb.M_AXI_AWVALID
                     : ifa.M_AXI_AWVALID;
  wire wvalid  = sel ? ifb.M_AXI_WVALID
                     : ifa.M_AXI_WVALID;
  wire bready  = sel ? ifb.M_AXI_BREADY
                     : ifa.M_AXI_BREADY;
  wire arvalid = sel ? ifb.M_AXI_ARVALID
                     : ifa.M_AXI_ARVALID;
  wire rready  = sel ? ifb.M_AXI_RREADY
                     : ifa.M_AXI_RREADY;
  wire [31:0] awaddr = sel ? ifb.M_AXI_AWADDR
                           : ifa.M_AXI_AWADDR;
  wire [31:0] araddr = sel ? ifb.M_AXI_ARADDR
                           : ifa.M_AXI_ARADDR;
  wire [31:0] wdata  = sel ? ifb.M_AXI_WDATA
                           : ifa.M_AXI_WDATA;
  wire [3:0]  wstrb  = sel ? ifb.M_AXI_WSTRB
                           : ifa.M_AXI_WSTRB;
  wire [2:0]  awprot = sel ? ifb.M_AXI_AWPROT
                           : ifa.M_AXI_AWPROT;
  wire [2:0]  arprot = sel ? ifb.M_AXI_ARPROT
                           : ifa.M_AXI_ARPROT;

  // slave model configuration (tb-written only)
  int aw_delay = 0;
  int w_delay  = 0;
  int berr_n   = 0;
  int b_base   = 0;
  int rerr_n   = 0;
  int ar_base  = 0;
  int poll_hit = 0;
  logic [31:0] rd_val = '0;

  // slave model state (slave-written only)
  int cyc = 0;
  int aw_wait = 0;
  int w_wait  = 0;
  int aw_cnt = 0;
  int w_cnt  = 0;
  int ar_cnt = 0;
  int b_total = 0;
  int cyc_aw = 0;
  int cyc_w  = 0;
  logic aw_got = 1'b0;
  logic w_got  = 1'b0;
  logic bvalid_r = 1'b0;
  logic rvalid_r = 1'b0;
  logic [1:0]  bresp_r = '0;
  logic [1:0]  rresp_r = '0;
  logic [31:0] rdata_r = '0;
  logic [31:0] last_awaddr = '0;
  logic [31:0] last_araddr = '0;
  logic [31:0] last_wdata  = '0;
  logic [3:0]  last_wstrb  = '0;
  logic [2:0]  last_awprot = '1;
  logic [2:0]  last_arprot = '0;

  wire s_awready = awvalid && (aw_wait >= aw_delay);
  wire s_wready  = wvalid && (w_wait >= w_delay);
  wire s_arready = arvalid;
  wire hs_aw = awvalid & s_awready;
  wire hs_w  = wvalid & s_wready;
  wire hs_ar = arvalid & s_arready;

  assign ifa.M_AXI_AWREADY = s_awready;
  assign ifa.M_AXI_WREADY  = s_wready;
  assign ifa.M_AXI_BVALID  = bvalid_r;
  assign ifa.M_AXI_BRESP   = bresp_r;
  assign ifa.M_AXI_ARREADY = s_arready;
  assign ifa.M_AXI_RVALID  = rvalid_r;
  assign ifa.M_AXI_RDATA   = rdata_r;
  assign ifa.M_AXI_RRESP   = rresp_r;
  assign ifb.M_AXI_AWREADY = s_awready;
  assign ifb.M_AXI_WREADY  = s_wready;
  assign ifb.M_AXI_BVALID  = bvalid_r;
  assign ifb.M_AXI_BRESP   = bresp_r;
  assign ifb.M_AXI_ARREADY = s_arready;
  assign ifb.M_AXI_RVALID  = rvalid_r;
  assign ifb.M_AXI_RDATA   = rdata_r;
  assign ifb.M_AXI_RRESP   = rresp_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait  <= 0;
      w_wait   <= 0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      bvalid_r <= 1'b0;
      rvalid_r <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      aw_wait <= (awvalid && !s_awready)
                 ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !s_wready)
                 ? w_wait + 1 : 0;
      if (hs_aw) begin
        aw_cnt      <= aw_cnt + 1;
        last_awaddr <= awaddr;
        last_awprot <= awprot;
        cyc_aw      <= cyc;
        aw_got      <= 1'b1;
      end
      if (hs_w) begin
        w_cnt      <= w_cnt + 1;
        last_wdata <= wdata;
        last_wstrb <= wstrb;
        cyc_w      <= cyc;
        w_got      <= 1'b1;
      end
      if ((aw_got || hs_aw) && (w_got || hs_w)
          && !bvalid_r) begin
        bvalid_r <= 1'b1;
        bresp_r  <= (b_total - b_base < berr_n)
                    ? 2'b10 : 2'b00;
        b_total  <= b_total + 1;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end
      if (bvalid_r && bready) bvalid_r <= 1'b0;
      if (hs_ar) begin
        rvalid_r    <= 1'b1;
        ar_cnt      <= ar_cnt + 1;
        last_araddr <= araddr;
        last_arprot <= arprot;
        rresp_r <= (ar_cnt - ar_base < rerr_n)
                   ? 2'b10 : 2'b00;
        if (poll_hit == 0)
          rdata_r <= rd_val;
        else
          rdata_r <=
            (ar_cnt - ar_base + 1 >= poll_hit)
            ? 32'h1 : 32'h0;
      end
      if (rvalid_r && rready) rvalid_r <= 1'b0;
    end
  end

  rsp_t exp_q[$];
  rsp_t got_q[$];

  // handshake completes on the following posedge
  always @(negedge clk)
    if (rst_n && rsp_valid && rsp_ready)
      got_q.push_back({rsp_data, rsp_status});

  task automatic send_cmd(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [31:0] m
  );
    logic r;
    r = 1'b0;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_mask  = m;
    cmd_valid = 1'b1;
    for (int n = 0; n < 100 && !r; n++) begin
      @(negedge clk);
      r = cmd_ready;
      @(posedge clk);
    end
    #1 cmd_valid = 1'b0;
    checks++;
    if (!r) begin
      $display("FAIL cmd_accept: ready=%b need 1",
               r);
      errors++;
    end
  endtask

  task automatic wait_rsp(
    output rsp_t act,
    output bit   ok
  );
    for (int n = 0; n < 600 && got_q.size() == 0;
         n++)
      @(posedge clk);
    #1;
    ok  = got_q.size() != 0;
    act = ok ? got_q.pop_front() : '0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0)
    begin
      $display("FAIL rst_ready: cr=%b rv=%b need 0",
               cmd_ready, rsp_valid);
      errors++;
    end
    checks++;
    if (rsp_status !== ST_OK) begin
      $display("FAIL rst_status: %b need 00",
               rsp_status);
      errors++;
    end
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready}
        !== 5'b0) begin
      $display("FAIL rst_axi: %b need 00000",
               {awvalid, wvalid, bready,
                arvalid, rready});
      errors++;
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL rst_release_ready: %b need 1",
               cmd_ready);
      errors++;
    end
  endtask

  task automatic test_write();
    rsp_t e, a;
    bit ok;
    int aw0, w0;
    aw0 = aw_cnt;
    w0  = w_cnt;
    aw_delay = 2;
    w_delay  = 0;
    berr_n   = 0;
    exp_q.push_back({32'hC, ST_OK});
    send_cmd(OP_WRITE, 32'h4000_0000, 32'hC, '0);
    wait_rsp(a, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || a !== e) begin
      $display("FAIL write_rsp: got %h need %h",
               a, e);
      errors++;
    end
    checks++;
    if (aw_cnt - aw0 !== 1 || w_cnt - w0 !== 1)
    begin
      $display("FAIL write_beats: aw=%0d w=%0d need 1",
               aw_cnt - aw0, w_cnt - w0);
      errors++;
    end
    checks++;
    if (last_wdata !== 32'hC
        || last_awaddr !== 32'h4000_0000) begin
      $display("FAIL write_bus: a=%h d=%h",
               last_awaddr, last_wdata);
      errors++;
    end
    checks++;
    if (cyc_aw - cyc_w !== 2) begin
      $display("FAIL write_aw_after_w: %0d need 2",
               cyc_aw - cyc_w);
      errors++;
    end
    checks++;
    if (last_awprot !== 3'b000
        || last_wstrb !== 4'hF) begin
      $display("FAIL write_prot_strb: %b %h",
               last_awprot, last_wstrb);
      errors++;
    end
    aw_delay = 0;
  endtask

  task automatic test_read_hold();
    rsp_t e, a;
    bit ok, held;
    int ar0;
    ar0 = ar_cnt;
    rd_val   = 32'h5;
    poll_hit = 0;
    rerr_n   = 0;
    rsp_ready = 1'b0;
    exp_q.push_back({32'h5, ST_OK});
    send_cmd(OP_READ, 32'h4001_0000, '0, '0);
    for (int n = 0; n < 100 && !rsp_valid; n++)
      @(negedge clk);
    held = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== 32'h5
          || rsp_status !== ST_OK || cmd_ready)
        held = 1'b0;
    end
    checks++;
    if (!held) begin
      $display("FAIL rsp_hold: v=%b d=%h cr=%b",
               rsp_valid, rsp_data, cmd_ready);
      errors++;
    end
    @(posedge clk) #1 rsp_ready = 1'b1;
    wait_rsp(a, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || a !== e) begin
      $display("FAIL read_rsp: got %h need %h",
               a, e);
      errors++;
    end
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
    begin
      $display("FAIL read_ready_back: cr=%b rv=%b",
               cmd_ready, rsp_valid);
      errors++;
    end
    checks++;
    if (last_arprot !== 3'b001
        || last_araddr !== 32'h4001_0000
        || ar_cnt - ar0 !== 1) begin
      $display("FAIL read_bus: p=%b a=%h n=%0d",
               last_arprot, last_araddr,
               ar_cnt - ar0);
      errors++;
    end
  endtask

  task automatic test_rmw();
    rsp_t e, a;
    bit ok;
    int aw0, ar0;
    aw0 = aw_cnt;
    ar0 = ar_cnt;
    rd_val = 32'hFF00;
    exp_q.push_back({32'hFFAB, ST_OK});
    send_cmd(OP_RMW, 32'h10, 32'h00AB, 32'h00FF);
    wait_rsp(a, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || a !== e) begin
      $display("FAIL rmw_rsp: got %h need %h", a, e);
      errors++;
    end
    checks++;
    if (last_wdata !== 32'hFFAB
        || last_awaddr !== 32'h10) begin
      $display("FAIL rmw_write: a=%h d=%h need 10 FFAB",
               last_awaddr, last_wdata);
      errors++;
    end
    checks++;
    if (aw_cnt - aw0 !== 1 || ar_cnt - ar0 !== 1)
    begin
      $display("FAIL rmw_beats: aw=%0d ar=%0d need 1",
               aw_cnt - aw0, ar_cnt - ar0);
      errors++;
    end
  endtask

  task automatic test_retry();
    rsp_t e, a;
    bit ok;
    int aw0;
    aw0 = aw_cnt;
    b_base = b_total;
    berr_n = 3;
    exp_q.push_back({32'h77, ST_OK});
    send_cmd(OP_WRITE, 32'h8, 32'h77, '0);
    wait_rsp(a, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || a !== e) begin
      $display("FAIL retry_ok_rsp: got %h need %h",
               a, e);
      errors++;
    end
    checks++;
    if (aw_cnt - aw0 !== 4) begin
      $display("FAIL retry_ok_beats: %0d need 4",
               aw_cnt - aw0);
      errors++;
    end
    sel = 1'b1;
    @(posedge clk) #1;
    aw0 = aw_cnt;
    b_base = b_total;
    berr_n = 1000;
    exp_q.push_back({32'h0, ST_AXI_ERR});
    send_cmd(OP_WRITE, 32'h8, 32'h99, '0);
    wait_rsp(a, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || a.st !== e.st) begin
      $display("FAIL retry_err_status: %b need %b",
               a.st, e.st);
      errors++;
    end
    checks++;
    if (aw_cnt - aw0 !== 3) begin
      $display("FAIL retry_err_beats: %0d need 3",
               aw_cnt - aw0);
      errors++;
    end
    berr_n = 0;
    sel = 1'b0;
    @(posedge clk) #1;
  endtask

  task automatic test_poll();
    rsp_t e, a;
    bit ok;
    poll_hit = 5;
    for (int k = 0; k < 2; k++) begin
      sel = (k == 1);
      @(posedge clk) #1;
      ar_base = ar_cnt;
      if (k == 0)
        exp_q.push_back({32'h1, ST_OK});
      else
        exp_q.push_back({32'h0, ST_POLL_LIM});
      send_cmd(OP_POLL, 32'h30, 32'h1, 32'h1);
      wait_rsp(a, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || a !== e) begin
        $display("FAIL poll_rsp%0d: got %h need %h",
                 k, a, e);
        errors++;
      end
      checks++;
      if (ar_cnt - ar_base !== (k == 0 ? 5 : 4))
      begin
        $display("FAIL poll_reads%0d: %0d need %0d",
                 k, ar_cnt - ar_base,
                 k == 0 ? 5 : 4);
        errors++;
      end
    end
    poll_hit = 0;
    sel = 1'b0;
    @(posedge clk) #1;
  endtask

  task automatic test_rmw_abort();
    rsp_t e, a;
    bit ok;
    int aw0;
    sel = 1'b1;
    @(posedge clk) #1;
    aw0 = aw_cnt;
    ar_base = ar_cnt;
    rerr_n = 1000;
    exp_q.push_back({32'h0, ST_AXI_ERR});
    send_cmd(OP_RMW, 32'h40, 32'h1, 32'h1);
    wait_rsp(a, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || a.st !== e.st) begin
      $display("FAIL rmw_abort_status: %b need %b",
               a.st, e.st);
      errors++;
    end
    checks++;
    if (ar_cnt - ar_base !== 3 || aw_cnt !== aw0)
    begin
      $display("FAIL rmw_abort_beats: ar=%0d aw=%0d",
               ar_cnt - ar_base, aw_cnt - aw0);
      errors++;
    end
    rerr_n = 0;
    sel = 1'b0;
    @(posedge clk) #1;
  endtask

  task automatic test_reset_mid();
    rsp_t e, a;
    bit ok, quiet;
    int aw0;
    aw_delay = 50;
    send_cmd(OP_WRITE, 32'h20, 32'hDEAD, '0);
    for (int n = 0; n < 20 && !awvalid; n++)
      @(negedge clk);
    checks++;
    if (awvalid !== 1'b1) begin
      $display("FAIL mid_awvalid_up: %b need 1",
               awvalid);
      errors++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0) begin
      $display("FAIL mid_awvalid_drop: aw=%b w=%b",
               awvalid, wvalid);
      errors++;
    end
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || cmd_ready) quiet = 1'b0;
    end
    checks++;
    if (!quiet || got_q.size() != 0) begin
      $display("FAIL mid_no_rsp: quiet=%b n=%0d",
               quiet, got_q.size());
      errors++;
    end
    aw_delay = 0;
    rst_n = 1'b1;
    @(posedge clk) #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL mid_ready: %b need 1",
               cmd_ready);
      errors++;
    end
    aw0 = aw_cnt;
    exp_q.push_back({32'h55, ST_OK});
    send_cmd(OP_WRITE, 32'h24, 32'h55, '0);
    wait_rsp(a, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || a !== e || aw_cnt - aw0 !== 1
        || last_wdata !== 32'h55) begin
      $display("FAIL mid_next: got %h need %h aw=%0d",
               a, e, aw_cnt - aw0);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_hold();
    test_rmw();
    test_retry();
    test_poll();
    test_rmw_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
